// File: rtl/serial_pkg.sv
// Shared serial-link definitions: FSM state encoding, line levels and default frame width.
// Used by the transmitter, the receiver and their benches.
package serial_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE  = 3'd0;
  localparam state_t START = 3'd1;
  localparam state_t DATA  = 3'd2;
  localparam state_t STOP  = 3'd3;
  localparam state_t BREAK = 3'd4;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam int DEFAULT_DATA_W = 8;

endpackage

// File: rtl/serial_receiver_sync.sv
// Generic 1-bit two-flop synchroniser with a programmable reset level.
// Latency: 2 clk; no backpressure.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial_receiver.sv
// Serial line receiver: mid-bit sampling, 1-deep valid/ready holding register, framing/overrun flags.
// Latency: byte_valid 1 clk after stop-bit sample; a full holding register drops new frames (overrun).
module serial_receiver
  import serial_pkg::*;
#(
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [DATA_W-1:0] byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_W + 1);

  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  logic              rx_s;
  state_t            state;
  logic [CW-1:0]     bit_cnt;
  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] shreg;

  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      idx        <= '0;
      shreg      <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      // A delivery later in this block overrides the accept-driven clear.
      if (byte_valid && byte_ready) begin
        byte_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (rx_s == START_BIT) begin
            state <= START;
          end
        end

        START: begin
          if (bit_cnt == HALF_M1) begin
            bit_cnt <= '0;
            idx     <= '0;
            state   <= (rx_s == START_BIT) ? DATA : IDLE;
          end else begin
            bit_cnt <= bit_cnt + CNT_ONE;
          end
        end

        DATA: begin
          if (bit_cnt == FULL_M1) begin
            bit_cnt <= '0;
            // LSB arrives first, so shifting in from the top leaves bit 0 in place after DATA_W bits.
            shreg   <= {rx_s, shreg[DATA_W-1:1]};
            idx     <= idx + IDX_ONE;
            if (idx == LAST_IDX) begin
              state <= STOP;
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_ONE;
          end
        end

        STOP: begin
          if (bit_cnt == FULL_M1) begin
            bit_cnt <= '0;
            if (rx_s == STOP_BIT) begin
              state <= IDLE;
              if (!byte_valid || byte_ready) begin
                byte_out   <= shreg;
                byte_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_ONE;
          end
        end

        BREAK: begin
          bit_cnt <= '0;
          if (rx_s == STOP_BIT) begin
            state <= IDLE;
          end
        end

        default: begin
          state   <= IDLE;
          bit_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_receiver.sv
// Scoreboard bench for serial_receiver: frames driven at 16 clk/bit, accepted bytes checked in order.
module tb_serial_receiver;
  import serial_pkg::*;

  localparam int CPB = 16;
  localparam int DW  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx = 1'b1;
  logic          byte_ready = 1'b0;
  logic [DW-1:0] byte_out;
  logic          byte_valid;
  logic          frame_err;
  logic          overrun;
  logic          busy;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  int            rd = 0;

  int   fe_cnt = 0;
  int   ov_cnt = 0;
  int   rise_cnt = 0;
  logic prev_vld = 1'b0;
  int   fe0, ov0, rs0;

  always #5 clk = ~clk;

  serial_receiver #(
    .DATA_W       (DW),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Samples between the driving negedge and the next posedge so inputs and outputs are settled.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (byte_valid && byte_ready) got_q.push_back(byte_out);
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (byte_valid && !prev_vld) rise_cnt++;
    end
    prev_vld = byte_valid;
  end

  // Start bit driven on the first negedge (N0); stop-bit mid-sample lands on posedge 155 after it.
  task automatic send_frame(input logic [DW-1:0] d, input logic stop);
    @(negedge clk);
    rx = START_BIT;
    for (int i = 0; i < DW; i++) begin
      repeat (CPB) @(negedge clk);
      rx = d[i];
    end
    repeat (CPB) @(negedge clk);
    rx = stop;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic snap();
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    rs0 = rise_cnt;
  endtask

  task automatic drain(input string tag);
    chk({tag, "_count"}, 32'(got_q.size() - rd), 32'(exp_q.size()));
    while (rd < got_q.size() && exp_q.size() > 0) begin
      chk(tag, 32'(got_q[rd]), 32'(exp_q.pop_front()));
      rd++;
    end
    exp_q.delete();
    rd = got_q.size();
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, 32'(byte_valid), 32'd0);
    chk({tag, "_byte"},  32'(byte_out),   32'd0);
    chk({tag, "_ferr"},  32'(frame_err),  32'd0);
    chk({tag, "_ovr"},   32'(overrun),    32'd0);
    chk({tag, "_busy"},  32'(busy),       32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 1: single frame, consumer ready, exact delivery cycle.
    byte_ready = 1'b1;
    snap();
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, STOP_BIT);
      begin
        repeat (155) @(negedge clk);
        chk("t1_valid_before", 32'(byte_valid), 32'd0);
        @(negedge clk);
        chk("t1_valid_at", 32'(byte_valid), 32'd1);
        chk("t1_byte_at", 32'(byte_out), 32'hA5);
      end
    join
    repeat (4) @(negedge clk);
    chk("t1_valid_drop", 32'(byte_valid), 32'd0);
    chk("t1_rises", 32'(rise_cnt - rs0), 32'd1);
    chk("t1_ferr", 32'(fe_cnt - fe0), 32'd0);
    chk("t1_ovr", 32'(ov_cnt - ov0), 32'd0);
    drain("t1_sb");

    // 2: low pulse shorter than half a bit is rejected at the start recheck.
    snap();
    @(negedge clk);
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    @(negedge clk);
    chk("t2_busy_during", 32'(busy), 32'd1);
    repeat (10) @(negedge clk);
    chk("t2_busy_after", 32'(busy), 32'd0);
    chk("t2_rises", 32'(rise_cnt - rs0), 32'd0);
    chk("t2_ferr", 32'(fe_cnt - fe0), 32'd0);
    drain("t2_sb");

    // 3: bad stop bit, line held low briefly, then a good frame.
    snap();
    send_frame(8'h3C, 1'b0);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    chk("t3_ferr", 32'(fe_cnt - fe0), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_rises_bad", 32'(rise_cnt - rs0), 32'd0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, STOP_BIT);
    repeat (4) @(negedge clk);
    chk("t3_rises_good", 32'(rise_cnt - rs0), 32'd1);
    chk("t3_ferr_total", 32'(fe_cnt - fe0), 32'd1);
    drain("t3_sb");

    // 4: consumer stalled, second frame overruns.
    byte_ready = 1'b0;
    snap();
    exp_q.push_back(8'h11);
    send_frame(8'h11, STOP_BIT);
    send_frame(8'h22, STOP_BIT);
    repeat (4) @(negedge clk);
    chk("t4_valid_held", 32'(byte_valid), 32'd1);
    chk("t4_byte_held", 32'(byte_out), 32'h11);
    chk("t4_ovr", 32'(ov_cnt - ov0), 32'd1);
    byte_ready = 1'b1;
    @(negedge clk);
    byte_ready = 1'b0;
    chk("t4_valid_drop", 32'(byte_valid), 32'd0);
    repeat (2) @(negedge clk);
    drain("t4_sb");

    // 5: accept of the old byte coincides with delivery of the new one.
    snap();
    exp_q.push_back(8'hAA);
    send_frame(8'hAA, STOP_BIT);
    repeat (4) @(negedge clk);
    exp_q.push_back(8'h55);
    fork
      send_frame(8'h55, STOP_BIT);
      begin
        repeat (155) @(negedge clk);
        byte_ready = 1'b1;
        @(negedge clk);
        byte_ready = 1'b0;
        chk("t5_valid_kept", 32'(byte_valid), 32'd1);
        chk("t5_byte_new", 32'(byte_out), 32'h55);
      end
    join
    repeat (4) @(negedge clk);
    chk("t5_ovr", 32'(ov_cnt - ov0), 32'd0);
    chk("t5_byte_stable", 32'(byte_out), 32'h55);
    byte_ready = 1'b1;
    @(negedge clk);
    byte_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_valid_drop", 32'(byte_valid), 32'd0);
    drain("t5_sb");

    // 6: reset in the middle of data bit 4 aborts the frame silently.
    byte_ready = 1'b1;
    snap();
    fork
      send_frame(8'hFF, STOP_BIT);
      begin
        repeat (81) @(negedge clk);
        chk("t6_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_idle_outputs("t6_rst");
        @(negedge clk);
        rst = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    chk("t6_rises_abort", 32'(rise_cnt - rs0), 32'd0);
    chk("t6_ferr_abort", 32'(fe_cnt - fe0), 32'd0);
    chk("t6_busy_after", 32'(busy), 32'd0);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, STOP_BIT);
    repeat (4) @(negedge clk);
    drain("t6_sb");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
